// File: rtl/ex_wb_reg.sv
// EX -> WB pipeline register with a one-entry skid buffer.
// Holds up to two results so a WB stall never drops an in-flight EX result.
// The head entry drives both the register-file write port and the bypass
// network. Entries leave strictly in push order.
module ex_wb_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_ex_i,
  output logic              ready_ex_o,
  input  logic [ADDR_W-1:0] rd_addr_ex_i,
  input  logic              rd_wr_en_ex_i,
  input  logic [DATA_W-1:0] result_ex_i,
  input  logic              flush_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [ADDR_W-1:0] rd_addr_wb_o,
  output logic              rd_wr_en_wb_o,
  output logic [DATA_W-1:0] rd_wdata_wb_o,
  output logic [1:0]        count_o
);

  // The state encoding is the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              push, pop;
  logic              cap_en;

  logic [ADDR_W-1:0] head_addr_q;
  logic              head_en_q;
  logic [DATA_W-1:0] head_data_q;

  logic [ADDR_W-1:0] skid_addr_q;
  logic              skid_en_q;
  logic [DATA_W-1:0] skid_data_q;

  logic load_head_in, load_head_skid, load_skid_in, clr_head, clr_skid;

  assign ready_ex_o = (state_q != S_TWO);
  assign wb_valid_o = (state_q != S_EMPTY);
  assign push       = valid_ex_i & ready_ex_o;
  assign pop        = wb_valid_o & wb_ready_i;

  // Writes to x0 are architecturally void; the entry still takes a slot.
  assign cap_en = rd_wr_en_ex_i & (rd_addr_ex_i != '0);

  // Occupancy state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  // Next-state and slot load/clear decisions; flush overrides push and pop.
  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid_in   = 1'b0;
    clr_head       = 1'b0;
    clr_skid       = 1'b0;
    if (flush_i) begin
      state_d  = S_EMPTY;
      clr_head = 1'b1;
      clr_skid = 1'b1;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (push) begin
            state_d      = S_ONE;
            load_head_in = 1'b1;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            load_head_in = 1'b1;
          end else if (push) begin
            state_d      = S_TWO;
            load_skid_in = 1'b1;
          end else if (pop) begin
            state_d  = S_EMPTY;
            clr_head = 1'b1;
          end
        end
        S_TWO: begin
          if (pop) begin
            state_d        = S_ONE;
            load_head_skid = 1'b1;
            clr_skid       = 1'b1;
          end
        end
        default: begin
          state_d  = S_EMPTY;
          clr_head = 1'b1;
          clr_skid = 1'b1;
        end
      endcase
    end
  end

  // Head entry: loaded from EX or promoted from skid; only the enable is
  // cleared when the slot empties, the other fields become don't-care.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_addr_q <= '0;
      head_en_q   <= 1'b0;
      head_data_q <= '0;
    end else if (load_head_in) begin
      head_addr_q <= rd_addr_ex_i;
      head_en_q   <= cap_en;
      head_data_q <= result_ex_i;
    end else if (load_head_skid) begin
      head_addr_q <= skid_addr_q;
      head_en_q   <= skid_en_q;
      head_data_q <= skid_data_q;
    end else if (clr_head) begin
      head_en_q   <= 1'b0;
    end
  end

  // Skid entry: catches the second result while WB is stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skid_addr_q <= '0;
      skid_en_q   <= 1'b0;
      skid_data_q <= '0;
    end else if (clr_skid) begin
      skid_addr_q <= '0;
      skid_en_q   <= 1'b0;
      skid_data_q <= '0;
    end else if (load_skid_in) begin
      skid_addr_q <= rd_addr_ex_i;
      skid_en_q   <= cap_en;
      skid_data_q <= result_ex_i;
    end
  end

  assign rd_addr_wb_o  = head_addr_q;
  assign rd_wr_en_wb_o = head_en_q & wb_valid_o;
  assign rd_wdata_wb_o = head_data_q;
  assign count_o       = state_q;

endmodule

// File: tb/tb_ex_wb_reg.sv
// Directed bench for ex_wb_reg: a table of per-cycle input/expected records
// plus hand-written reset and asynchronous-reset sequences.
module tb_ex_wb_reg;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_ex_i;
  logic        ready_ex_o;
  logic [4:0]  rd_addr_ex_i;
  logic        rd_wr_en_ex_i;
  logic [31:0] result_ex_i;
  logic        flush_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  rd_addr_wb_o;
  logic        rd_wr_en_wb_o;
  logic [31:0] rd_wdata_wb_o;
  logic [1:0]  count_o;

  ex_wb_reg #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .valid_ex_i    (valid_ex_i),
    .ready_ex_o    (ready_ex_o),
    .rd_addr_ex_i  (rd_addr_ex_i),
    .rd_wr_en_ex_i (rd_wr_en_ex_i),
    .result_ex_i   (result_ex_i),
    .flush_i       (flush_i),
    .wb_valid_o    (wb_valid_o),
    .wb_ready_i    (wb_ready_i),
    .rd_addr_wb_o  (rd_addr_wb_o),
    .rd_wr_en_wb_o (rd_wr_en_wb_o),
    .rd_wdata_wb_o (rd_wdata_wb_o),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        valid;
    logic [4:0]  addr;
    logic        en;
    logic [31:0] data;
    logic        wbr;
    logic        flush;
    logic [1:0]  x_cnt;
    logic        x_vld;
    logic        x_rdy;
    logic [4:0]  x_addr;
    logic        x_en;
    logic [31:0] x_data;
  } vec_t;

  vec_t vecs [64];
  int   nvec = 0;
  int   applied = 0;
  int   errors = 0;

  // Append one cycle: inputs driven before the edge, expectations after it.
  task automatic add(input logic v, input logic [4:0] a, input logic e,
                     input logic [31:0] d, input logic wbr, input logic fl,
                     input logic [1:0] xc, input logic xv, input logic xr,
                     input logic [4:0] xa, input logic xe, input logic [31:0] xd);
    vecs[nvec] = '{v, a, e, d, wbr, fl, xc, xv, xr, xa, xe, xd};
    nvec++;
  endtask

  // Compare all outputs; address/data only matter when the head is valid.
  task automatic check(input string name, input logic [1:0] xc, input logic xv,
                       input logic xr, input logic [4:0] xa, input logic xe,
                       input logic [31:0] xd);
    logic ok;
    applied++;
    ok = (count_o == xc) && (wb_valid_o == xv) && (ready_ex_o == xr) &&
         (rd_wr_en_wb_o == xe);
    if (xv) ok = ok && (rd_addr_wb_o == xa) && (rd_wdata_wb_o == xd);
    if (!ok) begin
      errors++;
      $display("FAIL %s: got cnt=%0d vld=%0b rdy=%0b rd=%0d en=%0b data=%h, want cnt=%0d vld=%0b rdy=%0b rd=%0d en=%0b data=%h",
               name, count_o, wb_valid_o, ready_ex_o, rd_addr_wb_o, rd_wr_en_wb_o,
               rd_wdata_wb_o, xc, xv, xr, xa, xe, xd);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic e,
                       input logic [31:0] d, input logic wbr, input logic fl);
    valid_ex_i    = v;
    rd_addr_ex_i  = a;
    rd_wr_en_ex_i = e;
    result_ex_i   = d;
    wb_ready_i    = wbr;
    flush_i       = fl;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100us");
    $fatal(1);
  end

  initial begin
    string nm;
    // Reset, with a push presented during reset that must be ignored.
    rst_i = 1'b1;
    drive(1'b1, 5'd3, 1'b1, 32'hAAAA_0003, 1'b0, 1'b0);
    #1;
    check("reset_state", 2'd0, 1'b0, 1'b1, 5'd0, 1'b0, 32'h0);
    @(posedge clk_i); #1;
    check("push_in_reset_ignored", 2'd0, 1'b0, 1'b1, 5'd0, 1'b0, 32'h0);
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Single push with WB ready, then drain.
    add(1, 5'd5, 1, 32'hDEAD_BEEF, 1, 0,  2'd1, 1, 1, 5'd5, 1, 32'hDEAD_BEEF);
    add(0, 5'd0, 0, 32'h0,         1, 0,  2'd0, 0, 1, 5'd0, 0, 32'h0);
    // WB stalled: fill head and skid, refuse a third, then drain A, B.
    add(1, 5'd1, 1, 32'h11, 0, 0,  2'd1, 1, 1, 5'd1, 1, 32'h11);
    add(1, 5'd2, 1, 32'h22, 0, 0,  2'd2, 1, 0, 5'd1, 1, 32'h11);
    add(1, 5'd3, 1, 32'h33, 0, 0,  2'd2, 1, 0, 5'd1, 1, 32'h11);
    add(0, 5'd0, 0, 32'h0,  1, 0,  2'd1, 1, 1, 5'd2, 1, 32'h22);
    add(0, 5'd0, 0, 32'h0,  1, 0,  2'd0, 0, 1, 5'd0, 0, 32'h0);
    // Streaming: one result per cycle, count stays 1.
    for (int i = 0; i < 8; i++)
      add(1, 5'(8 + i), 1, 32'h100 + 32'(i), 1, 0,
          2'd1, 1, 1, 5'(8 + i), 1, 32'h100 + 32'(i));
    add(0, 5'd0, 0, 32'h0, 1, 0,  2'd0, 0, 1, 5'd0, 0, 32'h0);
    // x0 destination: entry valid, write enable suppressed.
    add(1, 5'd0, 1, 32'h55, 0, 0,  2'd1, 1, 1, 5'd0, 0, 32'h55);
    add(0, 5'd0, 0, 32'h0,  1, 0,  2'd0, 0, 1, 5'd0, 0, 32'h0);
    // Flush from TWO with a concurrent pop; nothing stale may return.
    add(1, 5'd7, 1, 32'h77, 0, 0,  2'd1, 1, 1, 5'd7, 1, 32'h77);
    add(1, 5'd9, 1, 32'h99, 0, 0,  2'd2, 1, 0, 5'd7, 1, 32'h77);
    add(1, 5'd4, 1, 32'h44, 1, 1,  2'd0, 0, 1, 5'd0, 0, 32'h0);
    add(0, 5'd0, 0, 32'h0,  1, 0,  2'd0, 0, 1, 5'd0, 0, 32'h0);
    // Flush from ONE drops the push presented in the same cycle.
    add(1, 5'd4, 1, 32'h44, 0, 0,  2'd1, 1, 1, 5'd4, 1, 32'h44);
    add(1, 5'd6, 1, 32'h66, 0, 1,  2'd0, 0, 1, 5'd0, 0, 32'h0);
    add(0, 5'd0, 0, 32'h0,  0, 0,  2'd0, 0, 1, 5'd0, 0, 32'h0);
    // Back to back after flush: fresh entry appears normally.
    add(1, 5'd12, 1, 32'hC0FFEE, 0, 0,  2'd1, 1, 1, 5'd12, 1, 32'hC0FFEE);
    add(0, 5'd0, 0, 32'h0, 1, 0,  2'd0, 0, 1, 5'd0, 0, 32'h0);

    for (int i = 0; i < nvec; i++) begin
      drive(vecs[i].valid, vecs[i].addr, vecs[i].en, vecs[i].data,
            vecs[i].wbr, vecs[i].flush);
      @(posedge clk_i); #1;
      nm = $sformatf("vec%0d", i);
      check(nm, vecs[i].x_cnt, vecs[i].x_vld, vecs[i].x_rdy,
            vecs[i].x_addr, vecs[i].x_en, vecs[i].x_data);
    end

    // Asynchronous reset while in TWO: outputs clear before any clock edge.
    drive(1, 5'd10, 1, 32'hA0, 0, 0);
    @(posedge clk_i); #1;
    drive(1, 5'd11, 1, 32'hB0, 0, 0);
    @(posedge clk_i); #1;
    check("async_pre_two", 2'd2, 1'b1, 1'b0, 5'd10, 1'b1, 32'hA0);
    drive(0, 5'd0, 0, 32'h0, 0, 0);
    #2;
    rst_i = 1'b1;
    #1;
    check("async_reset_immediate", 2'd0, 1'b0, 1'b1, 5'd0, 1'b0, 32'h0);
    if (rd_addr_wb_o != 5'd0 || rd_wdata_wb_o != 32'h0) begin
      errors++;
      $display("FAIL async_reset_fields: got rd=%0d data=%h, want rd=0 data=0",
               rd_addr_wb_o, rd_wdata_wb_o);
    end
    applied++;
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(0, 5'd0, 0, 32'h0, 1, 0);
    @(posedge clk_i); #1;
    check("after_async_reset_idle", 2'd0, 1'b0, 1'b1, 5'd0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

endmodule
